io_pins_ctrl: RTL and testbench

- Command sequencer and arbiter in front of the 132-pin bidirectional pin bank.
- Shares the bank between NUM_REQ requesters using round-robin order.
- Owns the shadow output bytes and the single bank-wide write_enable. Sequences drive-to-sample turnaround so reads never sample pins it is driving.
- Returns one response per accepted command.

---
 rtl/io_pins_pkg.sv | 53 +++++
 rtl/io_pins_ctrl_rr_arbiter.sv | 55 +++++
 rtl/io_pins_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_io_pins_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pins_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pins_pkg
// Brief    : Shared types and sizing helpers for the pin-bank sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package io_pins_pkg;

    localparam int CMD_IDX_W = 8;
    localparam int CMD_ID_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_TURN   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    typedef struct packed {
        logic                 write;
        logic [CMD_IDX_W-1:0] index;
        logic [7:0]           wdata;
        logic [7:0]           wmask;
        logic [CMD_ID_W-1:0]  id;
    } cmd_t;

    function automatic int calc_num_bytes(input int pins);
        return (pins + 7) / 8;
    endfunction

    function automatic int calc_idx_w(input int nbytes);
        return (nbytes < 2) ? 1 : $clog2(nbytes);
    endfunction

    function automatic int calc_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Bits of the top byte that map onto real pins; a full byte when pins divide by 8.
    function automatic logic [7:0] last_byte_mask(input int pins);
        int rem;
        rem = pins % 8;
        if (rem == 0) begin
            return 8'hFF;
        end
        return 8'((1 << rem) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_pins_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin grant among NUM_REQ requesters; pointer advances past winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import io_pins_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [ID_W-1:0]    r_ptr_q;
    logic [ID_W-1:0]    w_ptr_d;
    logic [ID_W-1:0]    w_grant_id;
    logic [NUM_REQ-1:0] w_rot;
    int                 w_off;

    // Rotate so bit 0 is the pointer position, then pick the lowest set bit.
    always_comb begin
        w_rot = NUM_REQ'({i_req, i_req} >> r_ptr_q);
        w_off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k;
            end
        end
        w_grant_id = ID_W'((int'(r_ptr_q) + w_off) % NUM_REQ);
        o_grant    = (|i_req) ? (NUM_REQ'(1) << w_grant_id) : '0;
    end

    always_comb begin
        w_ptr_d = r_ptr_q;
        if (i_advance && (|i_req)) begin
            w_ptr_d = (int'(w_grant_id) == NUM_REQ - 1) ? '0 : w_grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_pins_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_pins_ctrl
// Brief    : Arbitrated command sequencer owning the pin-bank shadow and drive enable.
// Revision : 1.0 - initial release
// ============================================================================
module io_pins_ctrl
    import io_pins_pkg::*;
#(
    parameter int  PINS_CONT  = 132,
    parameter int  NUM_REQ    = 2,
    parameter int  TURNAROUND = 2,
    parameter int  SAMPLE_LAT = 1,
    localparam int NUM_BYTES  = calc_num_bytes(PINS_CONT),
    localparam int IDX_W      = calc_idx_w(NUM_BYTES)
) (
    input  logic                             CLK50,
    input  logic                             RST,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]    req_index,
    input  logic [NUM_REQ-1:0][7:0]          req_wdata,
    input  logic [NUM_REQ-1:0][7:0]          req_wmask,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [7:0]                       rsp_rdata,
    output logic                             rsp_error,
    output logic                             busy,
    output logic                             write_enable,
    output logic [0:NUM_BYTES-1][7:0]        output_pins_state,
    input  logic [0:NUM_BYTES-1][7:0]        input_pins_state
);

    localparam int         CNT_W     = calc_cnt_w(TURNAROUND, SAMPLE_LAT);
    localparam logic [7:0] LAST_MASK = last_byte_mask(PINS_CONT);

    function automatic logic [7:0] valid_bits(input int b);
        return (b == NUM_BYTES - 1) ? LAST_MASK : 8'hFF;
    endfunction

    state_e                    r_state_q,     w_state_d;
    cmd_t                      r_cmd_q,       w_cmd_d;
    logic                      r_err_q,       w_err_d;
    logic [CNT_W-1:0]          r_cnt_q,       w_cnt_d;
    logic                      r_we_q,        w_we_d;
    logic [0:NUM_BYTES-1][7:0] r_shadow_q,    w_shadow_d;
    logic [NUM_REQ-1:0]        r_rsp_valid_q, w_rsp_valid_d;
    logic [7:0]                r_rsp_rdata_q, w_rsp_rdata_d;
    logic                      r_rsp_error_q, w_rsp_error_d;

    logic [NUM_REQ-1:0]        w_arb_grant;
    logic                      w_accept;
    cmd_t                      w_gnt_cmd;
    logic                      w_gnt_err;
    logic [7:0]                w_gnt_rd_byte;
    logic [7:0]                w_cmd_rd_byte;
    logic [7:0]                w_old_byte;
    logic [7:0]                w_cmd_mask;
    logic [7:0]                w_new_byte;
    logic [NUM_REQ-1:0]        w_rsp_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (CLK50),
        .rst       (RST),
        .i_req     (req_valid),
        .i_advance (w_accept),
        .o_grant   (w_arb_grant)
    );

    assign w_accept  = (r_state_q == ST_IDLE) && (|req_valid) && !RST;
    assign req_ready = w_accept ? w_arb_grant : '0;

    always_comb begin
        w_gnt_cmd = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_arb_grant[k]) begin
                w_gnt_cmd.write = req_write[k];
                w_gnt_cmd.index = CMD_IDX_W'(req_index[k]);
                w_gnt_cmd.wdata = req_wdata[k];
                w_gnt_cmd.wmask = req_wmask[k];
                w_gnt_cmd.id    = CMD_ID_W'(k);
            end
        end
        w_gnt_err = (int'(w_gnt_cmd.index) >= NUM_BYTES);
    end

    // Byte selection for the latched command and, for zero-latency reads, the new grant.
    always_comb begin
        w_cmd_rd_byte = '0;
        w_gnt_rd_byte = '0;
        w_old_byte    = '0;
        w_cmd_mask    = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (int'(r_cmd_q.index) == b) begin
                w_cmd_rd_byte = input_pins_state[b] & valid_bits(b);
                w_old_byte    = r_shadow_q[b];
                w_cmd_mask    = valid_bits(b);
            end
            if (int'(w_gnt_cmd.index) == b) begin
                w_gnt_rd_byte = input_pins_state[b] & valid_bits(b);
            end
        end
        w_new_byte = ((w_old_byte & ~r_cmd_q.wmask) | (r_cmd_q.wdata & r_cmd_q.wmask)) & w_cmd_mask;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rsp_onehot[k] = (int'(r_cmd_q.id) == k);
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_cmd_d       = r_cmd_q;
        w_err_d       = r_err_q;
        w_cnt_d       = r_cnt_q;
        w_we_d        = r_we_q;
        w_shadow_d    = r_shadow_q;
        w_rsp_valid_d = '0;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_error_d = r_rsp_error_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cmd_d = w_gnt_cmd;
                    w_err_d = w_gnt_err;
                    if (w_gnt_err || w_gnt_cmd.write) begin
                        w_state_d = ST_WRITE;
                    end else begin
                        // Release the bank before any sampling can happen.
                        w_we_d = 1'b0;
                        if (r_we_q && (TURNAROUND > 0)) begin
                            w_state_d = ST_TURN;
                            w_cnt_d   = CNT_W'(TURNAROUND - 1);
                        end else if (SAMPLE_LAT > 0) begin
                            w_state_d = ST_SAMPLE;
                            w_cnt_d   = CNT_W'(SAMPLE_LAT - 1);
                        end else begin
                            w_state_d     = ST_RESP;
                            w_rsp_valid_d = w_arb_grant;
                            w_rsp_rdata_d = w_gnt_rd_byte;
                            w_rsp_error_d = 1'b0;
                        end
                    end
                end
            end
            ST_WRITE: begin
                w_state_d     = ST_RESP;
                w_rsp_valid_d = w_rsp_onehot;
                if (r_cmd_q.write && !r_err_q) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if (int'(r_cmd_q.index) == b) begin
                            w_shadow_d[b] = w_new_byte;
                        end
                    end
                    w_we_d        = 1'b1;
                    w_rsp_rdata_d = w_new_byte;
                    w_rsp_error_d = 1'b0;
                end else begin
                    w_rsp_rdata_d = 8'h00;
                    w_rsp_error_d = 1'b1;
                end
            end
            ST_TURN: begin
                if (r_cnt_q == '0) begin
                    if (SAMPLE_LAT > 0) begin
                        w_state_d = ST_SAMPLE;
                        w_cnt_d   = CNT_W'(SAMPLE_LAT - 1);
                    end else begin
                        w_state_d     = ST_RESP;
                        w_rsp_valid_d = w_rsp_onehot;
                        w_rsp_rdata_d = w_cmd_rd_byte;
                        w_rsp_error_d = 1'b0;
                    end
                end else begin
                    w_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (r_cnt_q == '0) begin
                    w_state_d     = ST_RESP;
                    w_rsp_valid_d = w_rsp_onehot;
                    w_rsp_rdata_d = w_cmd_rd_byte;
                    w_rsp_error_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50) begin
        if (RST) begin
            r_state_q     <= ST_IDLE;
            r_cmd_q       <= '0;
            r_err_q       <= 1'b0;
            r_cnt_q       <= '0;
            r_we_q        <= 1'b0;
            r_shadow_q    <= '0;
            r_rsp_valid_q <= '0;
            r_rsp_rdata_q <= '0;
            r_rsp_error_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cmd_q       <= w_cmd_d;
            r_err_q       <= w_err_d;
            r_cnt_q       <= w_cnt_d;
            r_we_q        <= w_we_d;
            r_shadow_q    <= w_shadow_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_error_q <= w_rsp_error_d;
        end
    end

    assign rsp_valid         = r_rsp_valid_q;
    assign rsp_rdata         = r_rsp_rdata_q;
    assign rsp_error         = r_rsp_error_q;
    assign busy              = (r_state_q != ST_IDLE);
    assign write_enable      = r_we_q;
    assign output_pins_state = r_shadow_q;

endmodule
`default_nettype wire

// File: tb/tb_io_pins_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_pins_ctrl
// Brief    : Randomized self-checking bench for io_pins_ctrl against a command-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_pins_ctrl;

    localparam int         PINS  = 132;
    localparam int         NR    = 2;
    localparam int         TA    = 2;
    localparam int         SL    = 1;
    localparam int         NB    = (PINS + 7) / 8;
    localparam int         REM   = PINS % 8;
    localparam logic [7:0] LASTM = (REM == 0) ? 8'hFF : 8'((1 << REM) - 1);

    logic                   CLK50;
    logic                   RST;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0]          req_write;
    logic [NR-1:0][4:0]     req_index;
    logic [NR-1:0][7:0]     req_wdata;
    logic [NR-1:0][7:0]     req_wmask;
    logic [NR-1:0]          rsp_valid;
    logic [7:0]             rsp_rdata;
    logic                   rsp_error;
    logic                   busy;
    logic                   write_enable;
    logic [0:NB-1][7:0]     output_pins_state;
    logic [0:NB-1][7:0]     pins_in;

    // Reference state: shadow bytes, drive direction, round-robin pointer.
    logic [0:NB-1][7:0]     m_shadow;
    logic                   m_we;
    int                     m_ptr;

    int n_tests;
    int n_fail;

    io_pins_ctrl #(
        .PINS_CONT  (PINS),
        .NUM_REQ    (NR),
        .TURNAROUND (TA),
        .SAMPLE_LAT (SL)
    ) dut (
        .CLK50             (CLK50),
        .RST               (RST),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_index         (req_index),
        .req_wdata         (req_wdata),
        .req_wmask         (req_wmask),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_error         (rsp_error),
        .busy              (busy),
        .write_enable      (write_enable),
        .output_pins_state (output_pins_state),
        .input_pins_state  (pins_in)
    );

    initial CLK50 = 1'b0;
    always #10 CLK50 = ~CLK50;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic randomize_pins();
        for (int b = 0; b < NB; b++) begin
            pins_in[b] = 8'($urandom);
        end
    endtask

    task automatic run_cmd(input int r, input bit wr, input int idx,
                           input logic [7:0] wd, input logic [7:0] wm);
        int         waitc;
        int         lat;
        int         exp_lat;
        bit         got;
        bit         exp_err;
        logic [7:0] exp_rd;

        exp_err = (idx >= NB);
        if (exp_err) begin
            exp_rd  = 8'h00;
            exp_lat = 2;
        end else if (wr) begin
            exp_rd = (m_shadow[idx] & ~wm) | (wd & wm);
            if (idx == NB - 1) exp_rd = exp_rd & LASTM;
            m_shadow[idx] = exp_rd;
            m_we    = 1'b1;
            exp_lat = 2;
        end else begin
            exp_rd = pins_in[idx];
            if (idx == NB - 1) exp_rd = exp_rd & LASTM;
            exp_lat = m_we ? (TA + SL + 1) : (SL + 1);
            m_we    = 1'b0;
        end

        @(posedge CLK50); #1;
        req_valid      = '0;
        req_valid[r]   = 1'b1;
        req_write[r]   = wr;
        req_index[r]   = 5'(idx);
        req_wdata[r]   = wd;
        req_wmask[r]   = wm;

        waitc = 0;
        got   = 1'b0;
        while (!got && waitc < 10) begin
            @(negedge CLK50);
            waitc++;
            got = req_ready[r];
        end
        chk("ready_seen", got, 1);
        if (!got) begin
            req_valid = '0;
            return;
        end
        chk("ready_onehot", req_ready, 1 << r);
        chk("busy_at_accept", busy, 0);
        m_ptr = (r + 1) % NR;

        @(posedge CLK50); #1;
        req_valid = '0;

        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(negedge CLK50);
            lat++;
            got = |rsp_valid;
            if (lat == 1 && !wr && !exp_err) chk("we_drop", write_enable, 0);
        end
        chk("rsp_seen", got, 1);
        if (!got) return;
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_valid", rsp_valid, 1 << r);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_error", rsp_error, exp_err);
        chk("busy_resp", busy, 1);
        chk("write_enable", write_enable, m_we);
        chk("shadow", output_pins_state, m_shadow);
        @(posedge CLK50); #1;
    endtask

    task automatic arb_phase(input int n_grants);
        int         grants;
        int         rsps;
        int         cyc;
        int         last_g;
        int         exp_g;
        logic [7:0] exp_rd;

        randomize_pins();
        req_write    = '0;
        req_wdata    = '0;
        req_wmask    = '0;
        req_index[0] = 5'd2;
        req_index[1] = 5'd9;
        @(posedge CLK50); #1;
        req_valid = '1;
        grants = 0;
        rsps   = 0;
        cyc    = 0;
        last_g = 0;
        while ((grants < n_grants || rsps < grants) && cyc < 200) begin
            @(negedge CLK50);
            cyc++;
            if (|rsp_valid) begin
                exp_rd = (last_g == 0) ? pins_in[2] : pins_in[9];
                chk("arb_rsp_valid", rsp_valid, 1 << last_g);
                chk("arb_rsp_rdata", rsp_rdata, exp_rd);
                rsps++;
            end
            if (|req_ready) begin
                exp_g = m_ptr;
                chk("arb_grant", req_ready, 1 << exp_g);
                last_g = exp_g;
                m_ptr  = (exp_g + 1) % NR;
                m_we   = 1'b0;
                grants++;
                if (grants == n_grants) begin
                    @(posedge CLK50); #1;
                    req_valid = '0;
                end
            end
        end
        req_valid = '0;
        chk("arb_grants", grants, n_grants);
        chk("arb_rsps", rsps, n_grants);
        @(posedge CLK50); #1;
    endtask

    task automatic reset_in_turn();
        int waitc;
        bit got;
        bit seen;

        run_cmd(0, 1'b1, 4, 8'h5A, 8'hFF);
        @(posedge CLK50); #1;
        req_valid    = '0;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_index[1] = 5'd6;
        waitc = 0;
        got   = 1'b0;
        while (!got && waitc < 10) begin
            @(negedge CLK50);
            waitc++;
            got = req_ready[1];
        end
        chk("rst_ready", got, 1);
        @(posedge CLK50); #1;
        req_valid = '0;
        RST       = 1'b1;
        @(negedge CLK50);
        chk("rst_busy_in_turn", busy, 1);
        chk("rst_we_in_turn", write_enable, 0);
        @(posedge CLK50); #1;
        RST      = 1'b0;
        m_shadow = '0;
        m_we     = 1'b0;
        m_ptr    = 0;
        @(negedge CLK50);
        chk("rst_we", write_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_shadow", output_pins_state, m_shadow);
        seen = 1'b0;
        repeat (8) begin
            @(negedge CLK50);
            if (|rsp_valid) seen = 1'b1;
        end
        chk("rst_no_rsp", seen, 0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_shadow  = '0;
        m_we      = 1'b0;
        m_ptr     = 0;
        RST       = 1'b1;
        req_valid = '1;
        req_write = '0;
        req_index = '0;
        req_wdata = '0;
        req_wmask = '0;
        pins_in   = '0;

        repeat (3) @(posedge CLK50);
        @(negedge CLK50);
        chk("reset_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_we", write_enable, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_error", rsp_error, 0);
        chk("reset_shadow", output_pins_state, m_shadow);
        req_valid = '0;
        @(posedge CLK50); #1;
        RST = 1'b0;

        run_cmd(0, 1'b1, 3, 8'hA5, 8'hFF);
        run_cmd(0, 1'b1, 3, 8'h0F, 8'h0F);
        randomize_pins();
        pins_in[7] = 8'h3C;
        run_cmd(1, 1'b0, 7, 8'h00, 8'h00);
        run_cmd(1, 1'b0, 7, 8'h00, 8'h00);
        run_cmd(0, 1'b1, NB - 1, 8'hFF, 8'hFF);
        run_cmd(1, 1'b1, 20, 8'h77, 8'hFF);
        randomize_pins();
        run_cmd(0, 1'b0, NB - 1, 8'h00, 8'h00);

        for (int t = 0; t < 40; t++) begin
            int         r;
            bit         wr;
            int         idx;
            logic [7:0] wm;
            r   = int'($urandom_range(0, NR - 1));
            wr  = 1'($urandom_range(0, 1));
            idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NB, 31))
                                               : int'($urandom_range(0, NB - 1));
            wm  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            randomize_pins();
            run_cmd(r, wr, idx, 8'($urandom), wm);
        end

        reset_in_turn();
        arb_phase(6);
        run_cmd(1, 1'b1, 0, 8'hC3, 8'hF0);
        run_cmd(0, 1'b0, 0, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
